// File: rtl/noc_vchannel_mux_pkg.sv
// Shared NoC definitions: channel-count limits and the round-robin
// first-request search used by the virtual-channel arbiters.
package optimsoc_noc_pkg;

  localparam int unsigned CHANNELS_MIN = 2;
  localparam int unsigned CHANNELS_MAX = 8;
  localparam int unsigned PTR_MAX_W    = 3;

  typedef logic [CHANNELS_MAX-1:0] ch_vec_t;
  typedef logic [PTR_MAX_W-1:0]    ch_idx_t;

  // One-hot grant of the first set bit of req at or above ptr, wrapping
  // modulo n. Zero when no bit in the low n positions is set.
  function automatic ch_vec_t rr_first(input ch_vec_t req, input ch_idx_t ptr,
                                       input int unsigned n);
    ch_vec_t     grant;
    logic        found;
    int unsigned idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < CHANNELS_MAX; i++) begin
      if (i < n) begin
        idx = 32'(ptr) + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/noc_vchannel_mux_arb.sv
// Combinational round-robin arbiter: req + search start pointer -> one-hot grant.
module noc_rr_arbiter
  import optimsoc_noc_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  ch_vec_t req_ext;
  ch_idx_t ptr_ext;
  ch_vec_t grant_full;

  // Widen to the package's fixed search width, search, narrow back.
  always_comb begin
    req_ext         = '0;
    req_ext[N-1:0]  = req;
    ptr_ext         = '0;
    ptr_ext[PW-1:0] = ptr;
    grant_full      = rr_first(req_ext, ptr_ext, N);
    grant           = grant_full[N-1:0];
  end

  if (N < CHANNELS_MAX) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^grant_full[CHANNELS_MAX-1:N];
  end

endmodule

// File: rtl/noc_vchannel_mux.sv
// Virtual-channel multiplexer: merges CHANNELS upstream channels onto one
// physical link with flit-granular round robin over channels that are both
// valid and ready downstream.
// Optional macro NOC_VCMUX_PKT_LOCK_EN: keep a started packet's channel at
// the head of the round robin until its last flit transfers.
module noc_vchannel_mux
  import optimsoc_noc_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned CHANNELS   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  in_flit,
  input  logic [CHANNELS-1:0]                  in_last,
  input  logic [CHANNELS-1:0]                  in_valid,
  output logic [CHANNELS-1:0]                  in_ready,
  output logic [FLIT_WIDTH-1:0]                out_flit,
  output logic                                 out_last,
  output logic [CHANNELS-1:0]                  out_valid,
  input  logic [CHANNELS-1:0]                  out_ready
);

  localparam int unsigned PTR_W = $clog2(CHANNELS);

  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
    $error("noc_vchannel_mux: CHANNELS out of range");
  end

  logic [PTR_W-1:0]    ptr, ptr_next, ptr_inc, grant_idx;
  logic [CHANNELS-1:0] in_pkt, in_pkt_next;
  logic [CHANNELS-1:0] cand, grant;
  logic                any_grant;

  // Candidates need both sides ready; reset masks every request.
  always_comb begin
    cand = in_valid & out_ready & {CHANNELS{rst}};
  end

  noc_rr_arbiter #(
    .N  (CHANNELS),
    .PW (PTR_W)
  ) u_arb (
    .req   (cand),
    .ptr   (ptr),
    .grant (grant)
  );

  // Route the granted channel onto the link; idle link drives zeros.
  always_comb begin
    grant_idx = '0;
    out_flit  = '0;
    out_last  = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (grant[c]) begin
        grant_idx = PTR_W'(c);
        out_flit  = in_flit[c];
        out_last  = in_last[c];
      end
    end
    any_grant = |grant;
    out_valid = grant;
    in_ready  = grant;
  end

  // Next pointer and per-channel packet state after a transfer.
  always_comb begin
    if (grant_idx == PTR_W'(CHANNELS - 1)) ptr_inc = '0;
    else                                   ptr_inc = grant_idx + PTR_W'(1);
    ptr_next    = ptr;
    in_pkt_next = in_pkt;
    if (any_grant) begin
      in_pkt_next[grant_idx] = ~out_last;
`ifdef NOC_VCMUX_PKT_LOCK_EN
      // ptr parks on a channel with an open packet; others may slip in
      // while it is blocked but never move ptr past it.
      if (in_pkt[ptr] && grant_idx != ptr) ptr_next = ptr;
      else if (!out_last)                  ptr_next = grant_idx;
      else                                 ptr_next = ptr_inc;
`else
      ptr_next = ptr_inc;
`endif
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr    <= '0;
      in_pkt <= '0;
    end else begin
      ptr    <= ptr_next;
      in_pkt <= in_pkt_next;
    end
  end

`ifndef SYNTHESIS
  logic                                prev_rst;
  logic [CHANNELS-1:0]                 prev_pending;
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] prev_flit;
  logic [CHANNELS-1:0]                 prev_last;

  // Remember offers that were not taken on the last edge.
  always_ff @(posedge clk) begin
    prev_rst     <= rst;
    prev_pending <= in_valid & ~grant;
    prev_flit    <= in_flit;
    prev_last    <= in_last;
  end

  // An offered but untaken flit must be held unchanged by upstream.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (rst && prev_rst && prev_pending[c]) begin
        assert (in_valid[c] && in_flit[c] == prev_flit[c] && in_last[c] == prev_last[c])
          else $error("noc_vchannel_mux: channel %0d changed a pending flit", c);
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_vchannel_mux.sv
// Scoreboard bench for noc_vchannel_mux (2-channel and 3-channel instances).
module tb_noc_vchannel_mux;

  typedef struct {
    logic [31:0] flit;
    logic        last;
  } src_t;

  typedef struct {
    int          ch;
    logic [31:0] flit;
    logic        last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][31:0] in_flit;
  logic [1:0]       in_last, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      out_flit;
  logic             out_last;

  logic [2:0][7:0]  b_in_flit;
  logic [2:0]       b_in_last, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]       b_out_flit;
  logic             b_out_last;

  int errors = 0;
  int checks = 0;

  src_t       src_q [2][$];
  exp_t       exp_q [$];
  logic [1:0] s_in_ready;

  always #5 clk = ~clk;

  noc_vchannel_mux #(.FLIT_WIDTH(32), .CHANNELS(2)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_flit(out_flit),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  noc_vchannel_mux #(.FLIT_WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .in_flit(b_in_flit), .in_last(b_in_last),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_flit(b_out_flit),
    .out_last(b_out_last), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  task automatic add_src(input int c, input logic [31:0] f, input logic l);
    src_q[c].push_back('{flit: f, last: l});
  endtask

  task automatic expect_xfer(input int c, input logic [31:0] f, input logic l);
    exp_q.push_back('{ch: c, flit: f, last: l});
  endtask

  task automatic refresh_inputs();
    for (int c = 0; c < 2; c++) begin
      if (src_q[c].size() > 0) begin
        in_valid[c] = 1'b1;
        in_flit[c]  = src_q[c][0].flit;
        in_last[c]  = src_q[c][0].last;
      end else begin
        in_valid[c] = 1'b0;
        in_flit[c]  = '0;
        in_last[c]  = 1'b0;
      end
    end
  endtask

  // One clock: sample at negedge, score any transfer, advance sources.
  task automatic step();
    logic [1:0] g;
    logic [1:0] oh;
    exp_t       e;
    @(negedge clk);
    g          = out_valid;
    s_in_ready = in_ready;
    checks++;
    if (in_ready !== out_valid) begin
      errors++;
      $display("FAIL ready_vs_grant: in_ready=%b out_valid=%b", in_ready, out_valid);
    end
    if (g != 2'b00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_xfer: out_valid=%b flit=%h, want no transfer", g, out_flit);
      end else begin
        e      = exp_q.pop_front();
        oh     = '0;
        oh[e.ch] = 1'b1;
        if (g !== oh || out_flit !== e.flit || out_last !== e.last) begin
          errors++;
          $display("FAIL xfer: out_valid=%b flit=%h last=%b, want out_valid=%b flit=%h last=%b",
                   g, out_flit, out_last, oh, e.flit, e.last);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++)
      if (g[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
    refresh_inputs();
  endtask

  task automatic drain(input int max_cycles, input string name, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d transfers outstanding after %0d cycles, want 0",
               name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    out_ready = 2'b11;
    add_src(0, 32'hA000_0000, 1'b1);
    add_src(1, 32'hB000_0000, 1'b1);
    refresh_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 2'b00 || in_ready !== 2'b00 || out_flit !== 32'h0 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: out_valid=%b in_ready=%b flit=%h last=%b, want all zero",
                 out_valid, in_ready, out_flit, out_last);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_grant: out_valid=%b, want 01", out_valid);
    end
    expect_xfer(0, 32'hA000_0000, 1'b1);
    expect_xfer(1, 32'hB000_0000, 1'b1);
    drain(10, "reset", n);
  endtask

  task automatic test_round_robin();
    int n;
    for (int i = 0; i < 4; i++) begin
      add_src(0, 32'h0200_0000 + i, 1'b1);
      add_src(1, 32'h0300_0000 + i, 1'b1);
      expect_xfer(0, 32'h0200_0000 + i, 1'b1);
      expect_xfer(1, 32'h0300_0000 + i, 1'b1);
    end
    refresh_inputs();
    drain(20, "rr", n);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL rr_cycles: took %0d cycles, want 8", n);
    end
  endtask

  task automatic test_blocked_channel();
    out_ready = 2'b10;
    add_src(0, 32'hC000_0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      add_src(1, 32'h0400_0000 + i, i == 2);
      expect_xfer(1, 32'h0400_0000 + i, i == 2);
    end
    refresh_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s_in_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL blocked_ready0: in_ready[0]=%b, want 0", s_in_ready[0]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL blocked_b2b: %0d ch1 flits still pending, want 0", exp_q.size());
      exp_q.delete();
    end
    out_ready = 2'b11;
    expect_xfer(0, 32'hC000_0000, 1'b1);
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL blocked_release: ch0 flit pending after out_ready rose, want sent");
      exp_q.delete();
    end
  endtask

  task automatic test_packet_order();
    int n;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    add_src(0, 32'h0500_0000, 1'b0);
    add_src(0, 32'h0500_0001, 1'b0);
    add_src(0, 32'h0500_0002, 1'b1);
    add_src(1, 32'h0600_0000, 1'b1);
`ifdef NOC_VCMUX_PKT_LOCK_EN
    expect_xfer(0, 32'h0500_0000, 1'b0);
    expect_xfer(0, 32'h0500_0001, 1'b0);
    expect_xfer(0, 32'h0500_0002, 1'b1);
    expect_xfer(1, 32'h0600_0000, 1'b1);
`else
    expect_xfer(0, 32'h0500_0000, 1'b0);
    expect_xfer(1, 32'h0600_0000, 1'b1);
    expect_xfer(0, 32'h0500_0001, 1'b0);
    expect_xfer(0, 32'h0500_0002, 1'b1);
`endif
    refresh_inputs();
    drain(10, "pkt", n);
  endtask

  task automatic test_reset_mid_packet();
    int n;
    add_src(1, 32'h0700_0000, 1'b0);
    add_src(1, 32'h0700_0001, 1'b0);
    add_src(1, 32'h0700_0002, 1'b1);
    expect_xfer(1, 32'h0700_0000, 1'b0);
    refresh_inputs();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midpkt_first: ch1 flit 1 not sent");
      exp_q.delete();
    end
    rst = 1'b0;
    src_q[1].delete();
    add_src(0, 32'h0800_0000, 1'b1);
    add_src(1, 32'h0900_0000, 1'b1);
    refresh_inputs();
    @(negedge clk);
    checks++;
    if (out_valid !== 2'b00 || in_ready !== 2'b00) begin
      errors++;
      $display("FAIL midpkt_in_reset: out_valid=%b in_ready=%b, want 00 00", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 2'b01) begin
      errors++;
      $display("FAIL midpkt_after_reset: out_valid=%b, want 01", out_valid);
    end
    expect_xfer(0, 32'h0800_0000, 1'b1);
    expect_xfer(1, 32'h0900_0000, 1'b1);
    drain(10, "midpkt", n);
  endtask

  task automatic test_three_channels();
    logic [2:0] want;
    int         cnt [3];
    for (int c = 0; c < 3; c++) cnt[c] = 0;
    b_in_valid = 3'b111;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      want        = '0;
      want[i % 3] = 1'b1;
      checks++;
      if (b_out_valid !== want || b_out_flit !== 8'(i % 3)) begin
        errors++;
        $display("FAIL ch3_rotation: cycle %0d out_valid=%b flit=%0d, want %b flit=%0d",
                 i, b_out_valid, b_out_flit, want, i % 3);
      end
      for (int c = 0; c < 3; c++) if (b_out_valid[c]) cnt[c]++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (cnt[0] != 3 || cnt[1] != 3 || cnt[2] != 3) begin
      errors++;
      $display("FAIL ch3_counts: %0d %0d %0d, want 3 3 3", cnt[0], cnt[1], cnt[2]);
    end
  endtask

  initial begin
    rst         = 1'b0;
    in_valid    = '0;
    in_flit     = '0;
    in_last     = '0;
    out_ready   = '0;
    b_in_flit   = {8'd2, 8'd1, 8'd0};
    b_in_last   = 3'b111;
    b_in_valid  = '0;
    b_out_ready = 3'b111;
    test_reset();
    test_round_robin();
    test_blocked_channel();
    test_packet_order();
    test_reset_mid_packet();
    test_three_channels();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
